master_interface: RTL

MASTER_INTERFACE -- requirements
Module: master_interface

---
 rtl/master_interface.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/master_interface.sv
// Serial bus master: accepts one user transaction, arbitrates for the bus,
// shifts the address (and write data) out LSB first, then for reads waits
// for the slave (with split support and a timeout) and shifts read data in.
//
// Handshake: the user side holds req high for one cycle while ready=1.
// mode, addr and wdata are captured in that cycle. The transaction ends with
// a one-cycle done pulse; err and rdata are valid with done. ready returns
// high in the cycle after done. On the bus side, bwdata is valid only while
// bwvalid=1, and brdata is used only while brvalid=1 and a read is waiting
// for or receiving data.
module master_interface #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req,
  output logic                  ready,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  err,
  output logic                  mbreq,
  input  logic                  mbgrant,
  output logic                  bwdata,
  output logic                  bmode,
  output logic                  bwvalid,
  input  logic                  brdata,
  input  logic                  brvalid,
  input  logic                  sready,
  input  logic                  ssplit
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WDATA, S_RWAIT, S_RDATA, S_DONE
  } state_t;

  state_t                state;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [CW-1:0]         bit_cnt;
  logic [15:0]           wait_cnt;
  logic                  frozen;

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      ready    <= 1'b1;
      mbreq    <= 1'b0;
      bwvalid  <= 1'b0;
      bwdata   <= 1'b0;
      bmode    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      mode_q   <= 1'b0;
      addr_sh  <= '0;
      wdata_sh <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      frozen   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            mode_q   <= mode;
            addr_sh  <= addr;
            wdata_sh <= wdata;
            ready    <= 1'b0;
            mbreq    <= 1'b1;
            rdata    <= '0;
            err      <= 1'b0;
            wait_cnt <= '0;
            frozen   <= 1'b0;
            bit_cnt  <= '0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mbgrant && sready) begin
            bwvalid <= 1'b1;
            bwdata  <= addr_sh[0];
            addr_sh <= addr_sh >> 1;
            bmode   <= mode_q;
            bit_cnt <= '0;
            state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bit_cnt == CW'(ADDR_WIDTH - 1)) begin
            bit_cnt <= '0;
            if (mode_q) begin
              bwdata   <= wdata_sh[0];
              wdata_sh <= wdata_sh >> 1;
              state    <= S_WDATA;
            end else begin
              bwvalid <= 1'b0;
              bwdata  <= 1'b0;
              state   <= S_RWAIT;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
            bwdata  <= addr_sh[0];
            addr_sh <= addr_sh >> 1;
          end
        end
        S_WDATA: begin
          if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
            bit_cnt <= '0;
            bwvalid <= 1'b0;
            bwdata  <= 1'b0;
            mbreq   <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b0;
            state   <= S_DONE;
          end else begin
            bit_cnt  <= bit_cnt + CW'(1);
            bwdata   <= wdata_sh[0];
            wdata_sh <= wdata_sh >> 1;
          end
        end
        S_RWAIT: begin
          // A split releases the bus and stops the timeout for good.
          if (ssplit) begin
            frozen <= 1'b1;
            mbreq  <= 1'b0;
          end
          if (brvalid) begin
            // Data wins over a timeout landing in the same cycle.
            rdata[0] <= brdata;
            bit_cnt  <= '0;
            if (DATA_WIDTH == 1) begin
              mbreq <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_RDATA;
            end
          end else if (!ssplit && !frozen) begin
            wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt + 16'd1 == 16'(TIMEOUT)) begin
              rdata <= '0;
              err   <= 1'b1;
              mbreq <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_RDATA: begin
          if (brvalid) begin
            rdata <= rdata | (DATA_WIDTH'(brdata) << (bit_cnt + CW'(1)));
            if (bit_cnt == CW'(DATA_WIDTH - 2)) begin
              bit_cnt <= '0;
              mbreq   <= 1'b0;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          ready <= 1'b1;
          bmode <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
